// File: rtl/seq_mul_feeder.sv
// Operand feeder and result capture stage for the 16x16 sequential multiplier.
// Tagged operand pairs are queued in a small FIFO, issued one at a time through
// the multiplier start/ready handshake, and each product is held for a
// downstream valid/ready handshake in strict request order.
module seq_mul_feeder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_a,
    input  logic [15:0]              in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     mul_start,
    input  logic                     mul_ready,
    output logic [15:0]              mul_multiplicand,
    output logic [15:0]              mul_multiplier,
    input  logic [31:0]              mul_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_product,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned EntW = TAG_W + 32;
    localparam logic [PtrW:0] LevelFull = (PtrW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StArm,
        StWait,
        StHold
    } state_e;

    // FIFO storage and bookkeeping
    logic [EntW-1:0] mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   level_q;

    // Control and registered outputs
    state_e          state_q;
    logic            mul_start_q;
    logic [15:0]     op_a_q;
    logic [15:0]     op_b_q;
    logic [TAG_W-1:0] op_tag_q;
    logic            out_valid_q;
    logic [31:0]     out_product_q;
    logic [TAG_W-1:0] out_tag_q;
    logic            busy_q;

    logic            push;
    logic            pop;
    logic            not_empty;
    logic [EntW-1:0] head;

    // Handshake decode: a pop happens when the FSM is free to take the next entry
    always_comb begin
        in_ready  = (level_q != LevelFull);
        not_empty = (level_q != '0);
        push      = in_valid && in_ready;
        pop       = not_empty &&
                    ((state_q == StIdle) || ((state_q == StHold) && out_ready));
        head      = mem_q[rd_ptr_q];
    end

    // FIFO pointers, occupancy and storage; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {in_tag, in_a, in_b};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Issue/capture FSM; ARM swallows the multiplier's stale ready from the last op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            mul_start_q   <= 1'b0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            op_tag_q      <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            out_tag_q     <= '0;
            busy_q        <= 1'b0;
        end else begin
            mul_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        op_tag_q    <= head[EntW-1 -: TAG_W];
                        op_a_q      <= head[31:16];
                        op_b_q      <= head[15:0];
                        mul_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    state_q <= StArm;
                end
                StArm: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (mul_ready) begin
                        out_product_q <= mul_product;
                        out_tag_q     <= op_tag_q;
                        out_valid_q   <= 1'b1;
                        state_q       <= StHold;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (pop) begin
                            op_tag_q    <= head[EntW-1 -: TAG_W];
                            op_a_q      <= head[31:16];
                            op_b_q      <= head[15:0];
                            mul_start_q <= 1'b1;
                            state_q     <= StIssue;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Output mapping
    always_comb begin
        mul_start        = mul_start_q;
        mul_multiplicand = op_a_q;
        mul_multiplier   = op_b_q;
        out_valid        = out_valid_q;
        out_product      = out_product_q;
        out_tag          = out_tag_q;
        busy             = busy_q;
        fifo_level       = level_q;
    end

endmodule

// File: tb/tb_seq_mul_feeder.sv
// Self-checking bench for seq_mul_feeder: behavioural signed multiplier model,
// order/tag scoreboard, table-driven single-op vectors and directed corner cases.
module tb_seq_mul_feeder;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             mul_start;
    logic             mul_ready;
    logic [15:0]      mul_multiplicand;
    logic [15:0]      mul_multiplier;
    logic [31:0]      mul_product;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_product;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
    logic [2:0]       fifo_level;

    seq_mul_feeder #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .in_tag           (in_tag),
        .mul_start        (mul_start),
        .mul_ready        (mul_ready),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product      (mul_product),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .out_tag          (out_tag),
        .busy             (busy),
        .fifo_level       (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] sprod(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] r;
        r = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- multiplier model (signed, shares rst) ----------------
    int   lat  = 5;
    bit   cont = 1'b0;
    logic m_busy;
    int   m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_ready   <= 1'b1;
            mul_product <= '0;
            m_busy      <= 1'b0;
            m_cnt       <= 0;
        end else if (cont) begin
            mul_ready   <= 1'b1;
            mul_product <= sprod(mul_multiplicand, mul_multiplier);
        end else if (mul_start) begin
            mul_ready <= 1'b0;
            m_busy    <= 1'b1;
            m_cnt     <= lat;
        end else if (m_busy) begin
            if (m_cnt <= 1) begin
                mul_ready   <= 1'b1;
                mul_product <= sprod(mul_multiplicand, mul_multiplier);
                m_busy      <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // ---------------- scoreboard and protocol monitors ----------------
    typedef struct packed {
        logic [15:0]      a;
        logic [15:0]      b;
        logic [TAG_W-1:0] tag;
    } req_t;

    req_t        exp_q[$];
    int          starts, results, pushes;
    int          start_edge, op_lat;
    logic        ov_prev, hs_prev, start_prev;
    logic [31:0] prod_prev;
    logic [TAG_W-1:0] tag_prev;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            starts     <= 0;
            results    <= 0;
            pushes     <= 0;
            start_edge <= 0;
            op_lat     <= 0;
            ov_prev    <= 1'b0;
            hs_prev    <= 1'b0;
            start_prev <= 1'b0;
            prod_prev  <= '0;
            tag_prev   <= '0;
        end else begin
            chk("in_ready_not_full", in_ready, fifo_level != 3'(DEPTH));
            if (fifo_level > 3'(DEPTH)) chk("level_bound", fifo_level, DEPTH);
            if (ov_prev && !hs_prev) begin
                chk("out_valid_held", out_valid, 1);
                chk("out_product_stable", out_product, prod_prev);
                chk("out_tag_stable", out_tag, tag_prev);
            end
            if (mul_start) begin
                chk("start_single_cycle", start_prev, 0);
                starts     <= starts + 1;
                start_edge <= cyc;
                op_lat     <= cont ? 1 : lat;
            end
            if (out_valid && !ov_prev) begin
                chk("capture_latency", cyc - start_edge, (op_lat + 2 > 3) ? op_lat + 2 : 3);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{a: in_a, b: in_b, tag: in_tag});
                pushes <= pushes + 1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    req_t e;
                    e = exp_q.pop_front();
                    chk("sb_product", out_product, sprod(e.a, e.b));
                    chk("sb_tag", out_tag, e.tag);
                    chk("one_start_per_op", starts, results + 1);
                end
                results <= results + 1;
            end
            ov_prev    <= out_valid;
            hs_prev    <= out_valid && out_ready;
            start_prev <= mul_start;
            prod_prev  <= out_product;
            tag_prev   <= out_tag;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
        in_a   = a;
        in_b   = b;
        in_tag = t;
    endtask

    // One op from idle: checks start timing, product, tag and return to idle.
    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                           input int l, input logic [31:0] exp);
        int k, first, nstart;
        lat = l;
        drive(a, b, t);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        k = 1;
        first = -1;
        nstart = 0;
        while (!out_valid && k < 200) begin
            if (mul_start) begin
                nstart++;
                if (first < 0) first = k;
            end
            step();
            k++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 0, 1);
            return;
        end
        chk("start_at_cycle2", first, 2);
        chk("start_count", nstart, 1);
        chk("out_product", out_product, exp);
        chk("out_tag", out_tag, t);
        chk("busy_in_hold", busy, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("out_valid_after_hs", out_valid, 0);
        chk("busy_after_hs", busy, 0);
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < bound) begin
            step();
            n++;
        end
        chk("drain_done", (exp_q.size() == 0) && !busy, 1);
    endtask

    task automatic wait_out_valid(input int bound);
        int n;
        n = 0;
        while (!out_valid && n < bound) begin
            step();
            n++;
        end
        chk("wait_out_valid", out_valid, 1);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
        int          l;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int r0, p0;
        bit seen;

        tbl[0] = '{16'h0003, 16'h0005, 4'h1, 17, 32'h0000_000F};
        tbl[1] = '{16'hFFFE, 16'h0007, 4'h2, 4,  32'hFFFF_FFF2};
        tbl[2] = '{16'h8000, 16'h8000, 4'h3, 1,  32'h4000_0000};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 4'h4, 2,  32'h0000_0001};
        tbl[4] = '{16'h7FFF, 16'h7FFF, 4'h5, 9,  32'h3FFF_0001};
        tbl[5] = '{16'h1234, 16'h0000, 4'h6, 3,  32'h0000_0000};
        tbl[6] = '{16'h0100, 16'hFF00, 4'hF, 6,  32'hFFFF_0000};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive(16'h0, 16'h0, 4'h0);
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_operands", {mul_multiplicand, mul_multiplier}, 0);
        chk("rst_out", {out_product, out_tag}, 0);
        rst = 1'b0;
        step();

        // Table-driven single operations
        for (int i = 0; i < 7; i++) begin
            run_one(tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].l, tbl[i].exp);
        end

        // Continuous mul_ready: ARM must ignore it (latency monitor checks capture edge)
        cont = 1'b1;
        step();
        run_one(16'h0011, 16'h0022, 4'h7, 1, 32'h0000_0242);
        run_one(16'hFFF0, 16'h0010, 4'h8, 1, 32'hFFFF_FF00);
        run_one(16'h0002, 16'hC000, 4'h9, 1, 32'hFFFF_8000);
        cont = 1'b0;
        step();

        // Back-pressure: six offers with results held
        lat = 3;
        r0 = results;
        p0 = pushes;
        for (int i = 0; i < 6; i++) begin
            drive(16'(i + 10), 16'(i + 20), 4'(i + 1));
            in_valid = 1'b1;
            step();
        end
        repeat (10) step();
        chk("full_level", fifo_level, 4);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        chk("full_accepted", pushes - p0, 5);
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain(300);
        chk("full_drained", results - r0, 5);
        out_ready = 1'b0;
        step();

        // Reset during WAIT with two entries queued
        lat = 40;
        for (int i = 0; i < 3; i++) begin
            drive(16'(i + 100), 16'(3), 4'(i + 4));
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (6) step();
        chk("pre_rst_level", fifo_level, 2);
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_level", fifo_level, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_operands", {mul_multiplicand, mul_multiplier}, 0);
        chk("arst_out", {out_product, out_tag, mul_start}, 0);
        step();
        step();
        rst = 1'b0;
        seen = 1'b0;
        repeat (60) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("no_out_valid_after_rst", seen, 0);
        run_one(16'h0006, 16'h0007, 4'hA, 5, 32'h0000_002A);

        // Simultaneous push and pop at level 2
        lat = 2;
        for (int i = 0; i < 3; i++) begin
            drive(16'(i + 1), 16'hFFFF, 4'(i + 11));
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        wait_out_valid(50);
        chk("pp_level_before", fifo_level, 2);
        drive(16'h0055, 16'h0002, 4'hE);
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("pp_level_after", fifo_level, 2);
        out_ready = 1'b1;
        wait_drain(300);
        out_ready = 1'b0;

        // Randomised traffic with wrap-around, both multiplier modes
        r0 = results;
        for (int ph = 0; ph < 2; ph++) begin
            cont = (ph == 1);
            for (int c = 0; c < 300; c++) begin
                drive(16'($urandom), 16'($urandom), 4'($urandom));
                in_valid  = ($urandom_range(0, 1) == 1);
                out_ready = ($urandom_range(0, 2) != 0);
                lat       = $urandom_range(1, 6);
                step();
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            wait_drain(500);
            out_ready = 1'b0;
        end
        cont = 1'b0;
        chk("random_enough_ops", (results - r0) >= 3 * DEPTH, 1);
        chk("all_pushes_returned", results, pushes);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/seq_mul_feeder.md
Name: seq_mul_feeder

Overview:
Upstream operand feeder and result capture stage for the 16x16 sequential multiplier. It buffers tagged operand pairs in a small FIFO and issues them one at a time through the multiplier start/ready handshake. It captures each 32-bit product and presents it downstream with a valid/ready handshake, preserving order and tag. The block does no arithmetic; the product is passed through bit-exact.

Parameters:
DEPTH, 4, operand FIFO entries; power of two, >= 2
TAG_W, 4, width of the opaque request tag carried with each operand pair

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair offered
in_ready  output  1  FIFO can accept; equals not-full
in_a  input  16  multiplicand
in_b  input  16  multiplier
in_tag  input  TAG_W  request tag
mul_start  output  1  one-cycle start pulse to multiplier
mul_ready  input  1  multiplier done/idle level
mul_multiplicand  output  16  operand A to multiplier, held for the whole operation
mul_multiplier  output  16  operand B to multiplier, held for the whole operation
mul_product  input  32  multiplier Product
out_valid  output  1  result available
out_ready  input  1  downstream accepts
out_product  output  32  captured product
out_tag  output  TAG_W  tag of captured product
busy  output  1  high in any state other than IDLE
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst=1) forces the following; all registers clear immediately, no handshake completes:
  - state=IDLE, FIFO empty, fifo_level=0, in_ready=1
  - mul_start=0; mul_multiplicand, mul_multiplier, out_product, out_tag all 0
  - out_valid=0, busy=0
- Reset mid-operation discards all queued and in-flight requests. The multiplier shares rst.
- FIFO push occurs when in_valid && in_ready. in_ready=0 when full. There is no full-bypass: a push and a pop in the same cycle while full is impossible because in_ready is low.
- Simultaneous push and pop when neither full nor empty leaves fifo_level unchanged. Pointers wrap modulo DEPTH.
- State machine:
  - IDLE: if FIFO non-empty, pop the head into the operand/tag registers and go to ISSUE.
  - ISSUE: mul_start=1 for exactly this cycle; go to ARM.
  - ARM: one cycle; mul_ready is ignored here, which covers the multiplier's stale ready from the previous op. Go to WAIT.
  - WAIT: on mul_ready=1, register mul_product into out_product, set out_valid=1, go to HOLD.
  - HOLD: out_valid held high with out_product/out_tag stable until out_ready=1. On that handshake:
    - if FIFO non-empty, pop the next entry and go to ISSUE, with out_valid low the next cycle;
    - else go to IDLE.
- A word pushed into an empty FIFO in IDLE at cycle 0 is popped at cycle 1, and mul_start is high at cycle 2.
- mul_multiplicand and mul_multiplier change only on a pop. They are stable from ISSUE through WAIT.
- Only one multiplication is in flight at a time. Results are delivered in strict FIFO order.
- out_valid never drops without an out_ready handshake. in_valid with in_ready=0 has no effect.
- mul_ready held high during WAIT completes immediately (minimum WAIT of 1 cycle).

Test Plan:
- Reset, push (a=3, b=5, tag=1); model multiplier returns 15 after 17 cycles -> mul_start at cycle 2 only; out_valid with out_product=0x0000000F, out_tag=1; busy=0 after the out_ready handshake.
- Push a=0xFFFE, b=0x0007 -> out_product equals model product 0xFFFFFFF2, passed through bit-exact.
- Hold out_ready=0 and offer 6 pairs with DEPTH=4:
  - fifo_level ends at 4, because one entry has been popped and one result is held.
  - in_ready=0 and the 6th pair is refused.
  - Releasing out_ready drains 5 results in push order with correct tags.
- Model drives mul_ready=1 continuously -> the ARM cycle ignores it; each op sees exactly one mul_start and a product captured the cycle after ARM.
- Assert rst during WAIT with 2 entries queued -> all outputs 0 immediately, fifo_level=0, no out_valid after release; the next push processes normally.
- Push and pop in the same cycle at level 2 -> level stays 2; wrap-around over 3xDEPTH transactions keeps order intact.
